// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: instruction width, field bit positions, opcodes,
// and the IF/ID buffer occupancy states.
package mips16_pkg;

    localparam int INSTR_W = 32;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int TGT_HI   = 25;
    localparam int TGT_LO   = 0;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_e;

    // Logical immediates are zero-extended in decode; everything else is signed.
    function automatic logic is_zext_op(input logic [5:0] opcode);
        return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    endfunction

endpackage

// File: rtl/ifid_stage_if.sv
// Fetch-side and decode-side signals of the IF/ID stage. The stage uses the
// slave modport; its environment (fetch + decode) uses master.
interface ifid_stage_if #(
    parameter int PC_W = 32
);
    logic                          if_valid;
    logic                          if_ready;
    logic [mips16_pkg::INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]               if_pc;
    logic                          flush;
    logic                          id_valid;
    logic                          id_ready;
    logic [PC_W-1:0]               id_pc;
    logic [5:0]                    id_opcode;
    logic [4:0]                    id_rs;
    logic [4:0]                    id_rt;
    logic [4:0]                    id_rd;
    logic [4:0]                    id_shamt;
    logic [5:0]                    id_funct;
    logic [15:0]                   id_imm16;
    logic [25:0]                   id_target;
`ifdef IFID_IMM_ZEXT_EN
    logic                          id_imm_zext;
`endif

    modport slave (
        input  if_valid, if_instr, if_pc, flush, id_ready,
`ifdef IFID_IMM_ZEXT_EN
        output id_imm_zext,
`endif
        output if_ready, id_valid, id_pc, id_opcode, id_rs, id_rt, id_rd,
               id_shamt, id_funct, id_imm16, id_target
    );

    modport master (
        output if_valid, if_instr, if_pc, flush, id_ready,
`ifdef IFID_IMM_ZEXT_EN
        input  id_imm_zext,
`endif
        input  if_ready, id_valid, id_pc, id_opcode, id_rs, id_rt, id_rd,
               id_shamt, id_funct, id_imm16, id_target
    );

endinterface

// File: rtl/ifid_fifo2.sv
// Two-entry {pc, instr} skid buffer with 1-bit wrapping pointers; the occupancy
// FSM (EMPTY/ONE/FULL) doubles as the entry count. Flush beats push and pop.
module ifid_fifo2
    import mips16_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               flush,
    output logic               pop_valid,
    input  logic               pop_ready,
    output logic [PC_W-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    fifo_state_e        state_q, state_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [PC_W-1:0]    pc_mem_q    [2];
    logic [PC_W-1:0]    pc_mem_d    [2];
    logic [INSTR_W-1:0] instr_mem_q [2];
    logic [INSTR_W-1:0] instr_mem_d [2];
    logic               push;
    logic               pop;

    // Handshake readiness comes only from registered state.
    assign push_ready = (state_q != ST_FULL);
    assign pop_valid  = (state_q != ST_EMPTY);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_instr = instr_mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (flush) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = push_pc;
                instr_mem_d[wr_ptr_q] = push_instr;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case (state_q)
                ST_EMPTY: if (push)         state_d = ST_ONE;
                ST_ONE:   if (push && !pop) state_d = ST_FULL;
                          else if (!push && pop) state_d = ST_EMPTY;
                ST_FULL:  if (pop)          state_d = ST_ONE;
                default:                    state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

endmodule

// File: rtl/ifid_stage.sv
// IF/ID stage: 2-entry buffer plus MIPS field split of the head instruction.
// Define IFID_IMM_ZEXT_EN to add the id_imm_zext output for logical immediates.
module ifid_stage
    import mips16_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    ifid_stage_if.slave  bus
);

    generate
        if (DEPTH != 2) begin : g_depth_check
            $error("ifid_stage: DEPTH must be 2");
        end
    endgenerate

    logic               head_valid;
    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [INSTR_W-1:0] instr_g;

    ifid_fifo2 #(.PC_W(PC_W)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.if_valid),
        .push_ready (bus.if_ready),
        .push_pc    (bus.if_pc),
        .push_instr (bus.if_instr),
        .flush      (bus.flush),
        .pop_valid  (head_valid),
        .pop_ready  (bus.id_ready),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    // Stale entry contents never leak out: everything reads 0 while empty.
    always_comb begin
        instr_g       = head_valid ? head_instr : '0;
        bus.id_valid  = head_valid;
        bus.id_pc     = head_valid ? head_pc : '0;
        bus.id_opcode = instr_g[OPC_HI:OPC_LO];
        bus.id_rs     = instr_g[RS_HI:RS_LO];
        bus.id_rt     = instr_g[RT_HI:RT_LO];
        bus.id_rd     = instr_g[RD_HI:RD_LO];
        bus.id_shamt  = instr_g[SHAMT_HI:SHAMT_LO];
        bus.id_funct  = instr_g[FUNCT_HI:FUNCT_LO];
        bus.id_imm16  = instr_g[IMM_HI:IMM_LO];
        bus.id_target = instr_g[TGT_HI:TGT_LO];
    end

`ifdef IFID_IMM_ZEXT_EN
    assign bus.id_imm_zext = head_valid & is_zext_op(instr_g[OPC_HI:OPC_LO]);
`endif

endmodule
